// File: rtl/serial_add_unit.sv
// serial_add_unit
// ---------------------------------------------------------------------------
// Bit-serial adder. A single full-adder cell with a registered carry
// processes one bit pair per clock, LSB first, so a WIDTH-bit addition takes
// WIDTH SHIFT cycles. The result is registered and announced with a one-cycle
// done pulse.
//
// Handshake: start is a request that is sampled only while the unit is IDLE;
// the edge that sees start=1 in IDLE is the accepting edge, and a, b and cin
// are captured there and nowhere else. busy is high for the WIDTH SHIFT
// cycles that follow. done is high for exactly one cycle, the DONE cycle,
// during which sum/cout (and ovf) carry the new result. start seen during
// SHIFT or DONE is dropped, not queued.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        operation request (IDLE only)
//   a, b         WIDTH-bit unsigned operands, captured on accept
//   cin          carry-in, captured on accept
//   busy         high while in SHIFT
//   done         one-cycle result-valid pulse
//   sum          last completed sum, held until the next completion
//   cout         last completed carry-out, held likewise
//   ovf          (SERIAL_ADD_OVF_EN only) signed overflow of the last result
//   dbg_state_o  current FSM state encoding (0 IDLE, 1 SHIFT, 2 DONE)
//
// Optional feature macro: SERIAL_ADD_OVF_EN adds the ovf output and its flop.
// ---------------------------------------------------------------------------
module serial_add_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef SERIAL_ADD_OVF_EN
  output logic             ovf,
`endif
  output logic [1:0]       dbg_state_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  // Full-adder cell on the current LSBs and the carry flop.
  logic fa_s, fa_c;
  assign fa_s = sa_q[0] ^ sb_q[0] ^ carry_q;
  assign fa_c = (sa_q[0] & sb_q[0]) | (sa_q[0] & carry_q) | (sb_q[0] & carry_q);

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        done_d = 1'b0;
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          carry_d = cin;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // Sum bits enter at the MSB so after WIDTH shifts bit 0 is the LSB.
        acc_d   = {fa_s, acc_q[WIDTH-1:1]};
        sa_d    = sa_q >> 1;
        sb_d    = sb_q >> 1;
        carry_d = fa_c;
        if (cnt_q == CNT_LAST) begin
          // Counter is cleared rather than incremented so it never wraps.
          cnt_d   = '0;
          sum_d   = {fa_s, acc_q[WIDTH-1:1]};
          cout_d  = fa_c;
`ifdef SERIAL_ADD_OVF_EN
          // carry_q here is the carry into the MSB position.
          ovf_d   = carry_q ^ fa_c;
`endif
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        done_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign sum         = sum_q;
  assign cout        = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf         = ovf_q;
`endif
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_serial_add_unit.sv
// Directed bench for serial_add_unit: a WIDTH=8 instance for the directed
// cases and a WIDTH=4 instance for the full operand sweep. Inputs are driven
// and outputs sampled on the falling clock edge.
module tb_serial_add_unit;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT W=8 ----------------
  logic       start8, cin8;
  logic [7:0] a8, b8;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;
  logic [1:0] st8;
`ifdef SERIAL_ADD_OVF_EN
  logic       ovf8;
`endif

  serial_add_unit #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8),
`ifdef SERIAL_ADD_OVF_EN
    .ovf(ovf8),
`endif
    .dbg_state_o(st8)
  );

  // ---------------- DUT W=4 ----------------
  logic       start4, cin4;
  logic [3:0] a4, b4;
  logic       busy4, done4, cout4;
  logic [3:0] sum4;
  logic [1:0] st4;
`ifdef SERIAL_ADD_OVF_EN
  logic       ovf4;
`endif

  serial_add_unit #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4),
`ifdef SERIAL_ADD_OVF_EN
    .ovf(ovf4),
`endif
    .dbg_state_o(st4)
  );

  // ---------------- scoreboard counters ----------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One W=8 operation: request, then wait (bounded) for done and check
  // latency (edges after the accepting edge) and the result.
  task automatic op8(input logic [7:0] oa, input logic [7:0] ob, input logic oc,
                     input logic [7:0] es, input logic ec, input logic eo,
                     input string tag);
    int lat;
    @(negedge clk);
    start8 = 1'b1; a8 = oa; b8 = ob; cin8 = oc;
    @(negedge clk);               // accepting edge has passed
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
    check({tag, "_busy"}, {31'd0, busy8}, 32'd1);
    lat = 0;
    while (!done8 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, lat, 32'd8);
    check({tag, "_sum"}, {24'd0, sum8}, {24'd0, es});
    check({tag, "_cout"}, {31'd0, cout8}, {31'd0, ec});
`ifdef SERIAL_ADD_OVF_EN
    check({tag, "_ovf"}, {31'd0, ovf8}, {31'd0, eo});
`else
    if (eo === 1'bx) $display("unused ovf expectation");
`endif
  endtask

  task automatic op4(input logic [3:0] oa, input logic [3:0] ob, input logic oc);
    int lat;
    logic [4:0] full;
    logic       eovf;
    full = {1'b0, oa} + {1'b0, ob} + {4'd0, oc};
    eovf = (oa[3] ~^ ob[3]) & (full[3] ^ oa[3]);
    @(negedge clk);
    start4 = 1'b1; a4 = oa; b4 = ob; cin4 = oc;
    @(negedge clk);
    start4 = 1'b0;
    lat = 0;
    while (!done4 && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    check($sformatf("w4_%0h_%0h_%0d", oa, ob, oc),
          {23'd0, lat[3:0], cout4, sum4}, {23'd0, 4'd4, full});
`ifdef SERIAL_ADD_OVF_EN
    check($sformatf("w4ovf_%0h_%0h_%0d", oa, ob, oc), {31'd0, ovf4}, {31'd0, eovf});
`else
    if (eovf === 1'bx) $display("unused ovf expectation");
`endif
    @(negedge clk);               // DONE -> IDLE
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int lat;
    int n_done;
    int spurious;
    int t_done[3];
    int cyc;

    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    #22;
    check("rst_busy", {31'd0, busy8}, 32'd0);
    check("rst_done", {31'd0, done8}, 32'd0);
    check("rst_sum",  {24'd0, sum8}, 32'd0);
    check("rst_cout", {31'd0, cout8}, 32'd0);
    check("rst_state", {30'd0, st8}, 32'd0);
    check("rst4_out", {26'd0, busy4, done4, cout4, sum4[2:0]} | {27'd0, sum4[3], 4'd0}, 32'd0);
`ifdef SERIAL_ADD_OVF_EN
    check("rst_ovf", {31'd0, ovf8}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Carry ripples all the way out.
    op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "ff_01");
    @(negedge clk);
    check("ff_01_idle", {30'd0, st8}, 32'd0);
    check("ff_01_done_1cyc", {31'd0, done8}, 32'd0);

    // Positive + positive into the sign bit.
    op8(8'h35, 8'h4A, 1'b1, 8'h80, 1'b0, 1'b1, "35_4a");
    @(negedge clk);

    // Requests during SHIFT and DONE are ignored.
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0;
    @(negedge clk);
    a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1;   // start stays high through SHIFT
    check("ign_state_shift", {30'd0, st8}, 32'd1);
    check("ign_sum_held", {24'd0, sum8}, 32'h80);
    lat = 0;
    while (!done8 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("ign_lat", lat, 32'd8);
    check("ign_sum", {24'd0, sum8}, 32'h30);
    check("ign_busy_in_done", {31'd0, busy8}, 32'd0);
    check("ign_state_done", {30'd0, st8}, 32'd2);
    @(negedge clk);                 // start was high during DONE as well
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    spurious = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8 || busy8) spurious++;
    end
    check("ign_no_second_op", spurious, 32'd0);
    check("ign_sum_final", {24'd0, sum8}, 32'h30);

    // Reset in the middle of an operation.
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h7F; b8 = 8'h7F; cin8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_busy_pre", {31'd0, busy8}, 32'd1);
    check("abort_sum_pre", {24'd0, sum8}, 32'h30);
    #2 rst_n = 1'b0;
    #1;
    check("abort_sum", {24'd0, sum8}, 32'd0);
    check("abort_flags", {29'd0, busy8, done8, cout8}, 32'd0);
    check("abort_state", {30'd0, st8}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    spurious = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8 || busy8) spurious++;
    end
    check("abort_no_done", spurious, 32'd0);
    op8(8'h7F, 8'h7F, 1'b0, 8'hFE, 1'b0, 1'b1, "7f_7f");
    @(negedge clk);

    // start held high: back-to-back operations.
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0;
    n_done = 0;
    cyc = 0;
    while (n_done < 3 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (done8) begin
        t_done[n_done] = cyc;
        check($sformatf("b2b_sum%0d", n_done), {24'd0, sum8}, 32'h02);
        check($sformatf("b2b_cout%0d", n_done), {31'd0, cout8}, 32'd0);
        n_done++;
        if (n_done == 3) start8 = 1'b0;
      end
    end
    check("b2b_count", n_done, 32'd3);
    if (n_done == 3) begin
      check("b2b_gap1", t_done[1] - t_done[0], 32'd10);
      check("b2b_gap2", t_done[2] - t_done[1], 32'd10);
    end
    @(negedge clk);

    // WIDTH=4 full sweep.
    for (int ia = 0; ia < 16; ia++)
      for (int ib = 0; ib < 16; ib++)
        for (int ic = 0; ic < 2; ic++)
          op4(4'(ia), 4'(ib), 1'(ic));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_add_unit.md
Name: serial_add_unit

Overview:
- Bit-serial adder built around a single full-adder cell plus a registered carry; consumes the cell's sum/carry once per clock, LSB first.
- Adds two WIDTH-bit operands and a carry-in over WIDTH cycles, then presents a registered result with a one-cycle done pulse.
- Sits in the arithmetic lab datapath as the sequential stage downstream of the full-adder cell. Trades area for latency against a ripple adder.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  operand A; captured on accepted start
- b  input  WIDTH  operand B; captured on accepted start
- cin  input  1  carry-in; captured on accepted start
- busy  output  1  high while in SHIFT
- done  output  1  one-cycle pulse; result valid
- sum  output  WIDTH  last completed sum; held until next completion
- cout  output  1  last completed carry-out; held until next completion

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset: state=IDLE. busy=0, done=0, sum=0, cout=0. All internal shift registers, the carry flop and the counter are 0.
- States:
  - IDLE: busy=0, done=0. start=1 at edge k loads sa<=a, sb<=b, carry<=cin, cnt<=0, and moves to SHIFT.
  - SHIFT: busy=1. Each edge computes s=sa[0]^sb[0]^carry and c=majority(sa[0],sb[0],carry). It then does: acc<={s,acc[WIDTH-1:1]}, sa>>=1, sb>>=1, carry<=c, cnt<=cnt+1. On the edge where cnt==WIDTH-1 (edge k+WIDTH), it also sets sum<={s,acc[WIDTH-1:1]}, cout<=c, and moves to DONE.
  - DONE: done=1 and busy=0 for exactly one cycle. Returns to IDLE unconditionally on the next edge.
- Latency: start sampled at edge k, result and done visible after edge k+WIDTH. Throughput is one operation per WIDTH+2 cycles.
- start in SHIFT or DONE is ignored. No queuing; operands are not re-sampled.
- Operand inputs are don't-care except at the accepting edge.
- sum/cout change only on the completing edge. Partial results are never visible on the outputs.
- cnt is $clog2(WIDTH) bits and never wraps mid-operation. The terminal compare is cnt==WIDTH-1.
- Arithmetic: {cout,sum} == a+b+cin, computed modulo 2^(WIDTH+1). Operands are unsigned.
- Reset asserted mid-operation aborts immediately: all outputs 0, state IDLE. Completion of the aborted operation is never reported.
- start high continuously: a new operation is accepted in each IDLE cycle, i.e. every WIDTH+2 cycles.

Optional Feature:
- Macro: SERIAL_ADD_OVF_EN.
- Defined: adds output ovf (1 bit), signed two's-complement overflow. ovf = carry-into-MSB XOR carry-out.
  - Carry-into-MSB is the carry flop value during the final SHIFT cycle.
  - ovf is registered on the completing edge alongside sum/cout, held like sum, and resets to 0.
- Not defined: port ovf is absent and no extra flop is generated. All other behaviour is identical.

Test Plan:
- WIDTH=8; a=8'hFF, b=8'h01, cin=0, start pulse -> done exactly 8 cycles after the accepting edge; sum=8'h00, cout=1; ovf=0 if enabled.
- WIDTH=8; a=8'h35, b=8'h4A, cin=1 -> sum=8'h80, cout=0; with SERIAL_ADD_OVF_EN, ovf=1.
- WIDTH=8; start accepted with a=8'h10, b=8'h20. Then start re-asserted with a=8'hAA, b=8'h55 during SHIFT and during DONE -> both ignored; one done pulse, sum=8'h30. busy low in DONE.
- WIDTH=8; a=8'h7F, b=8'h7F; rst_n pulsed low after 4 SHIFT cycles -> outputs 0 asynchronously; no done pulse follows. A fresh start after release yields sum=8'hFE, cout=0.
- WIDTH=4; exhaustive sweep of all a, b, cin (512 cases), as in the full-adder cell bench -> every done shows {cout,sum}==a+b+cin. Zero mismatches reported.
- WIDTH=8; start held high for 3 operations with a=8'h01, b=8'h01, cin=0 -> done pulses exactly 10 cycles apart, each with sum=8'h02 and cout=0.
